// File: rtl/rice_pkg.sv
// Shared state encoding and helpers for the adaptive Rice encoder.
package rice_pkg;

  typedef enum logic [1:0] {
    FILL,
    CALC,
    EMIT
  } enc_state_e;

  localparam int ZW     = 32;
  localparam int SW_MAX = 64;
  localparam int KW     = 4;

  // Width w selects the sign bit; the result is masked to w bits.
  function automatic logic [ZW-1:0] zigzag(
    input logic [ZW-1:0] x,
    input int            w
  );
    logic [ZW-1:0] u;
    u = {x[ZW-2:0], 1'b0};
    if (x[w-1]) u = ~u;
    return u & ~({ZW{1'b1}} << w);
  endfunction

  function automatic logic [KW-1:0] rice_k_select(
    input logic [SW_MAX-1:0] s,
    input int                log2n,
    input int                kmax
  );
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < 16; i++) begin
      if (i <= kmax && (s >> (log2n + i)) != '0) k = KW'(i);
    end
    return k;
  endfunction

endpackage

// File: rtl/rice_k_select.sv
// Rice parameter search: largest k in [0,KMAX] with (S >> (LOG2_N+k)) != 0.
module rice_k_select
  import rice_pkg::*;
#(
  parameter int SW     = 20,
  parameter int LOG2_N = 4,
  parameter int KMAX   = 14
) (
  input  logic [SW-1:0] iSum,
  output logic [KW-1:0] oK
);

  assign oK = rice_pkg::rice_k_select(SW_MAX'(iSum), LOG2_N, KMAX);

endmodule

// File: rtl/adaptive_rice_encoder.sv
// Partition-adaptive Rice encoder: FILL -> CALC -> EMIT per partition.
// Define RICE_PART_BITS_EN to add the oPartBits running-total output.
module adaptive_rice_encoder
  import rice_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LOG2_N = 4,
  parameter int KMAX   = 14
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic                iValid,
  input  logic [WIDTH-1:0]    iSample,
  output logic                oReady,
  output logic                oValid,
  input  logic                iReady,
  output logic [WIDTH-1:0]    oMSB,
  output logic [KMAX:0]       oLSB,
  output logic [WIDTH:0]      oBitsUsed,
  output logic [3:0]          oParam,
  output logic                oFirst,
  output logic                oLast
`ifdef RICE_PART_BITS_EN
  ,
  output logic [WIDTH+LOG2_N:0] oPartBits
`endif
);

  localparam int N  = 1 << LOG2_N;
  localparam int SW = WIDTH + LOG2_N;
  localparam int LW = KMAX + 1;
  localparam int BW = WIDTH + 1;

  enc_state_e        state_q;
  logic [LOG2_N-1:0] ptr_q;
  logic [SW-1:0]     sum_q;
  logic [WIDTH-1:0]  buf_q [N];
  logic [3:0]        k_q;
  logic [3:0]        k_calc;

  logic [WIDTH-1:0]  u_in;
  logic              take;
  logic              hs;
  logic [LOG2_N-1:0] sel;
  logic [3:0]        ksel;
  logic [WIDTH-1:0]  u_sel;
  logic [LW-1:0]     mask;
  logic [WIDTH-1:0]  msb_d;
  logic [LW-1:0]     lsb_d;
  logic [BW-1:0]     bits_d;

  assign u_in   = WIDTH'(zigzag(ZW'(iSample), WIDTH));
  assign oReady = (state_q == FILL);
  assign take   = oReady & iValid;
  assign hs     = oValid & iReady;
  assign oParam = k_q;

  rice_k_select #(
    .SW    (SW),
    .LOG2_N(LOG2_N),
    .KMAX  (KMAX)
  ) u_ksel (
    .iSum(sum_q),
    .oK  (k_calc)
  );

  // Word to load next: entry 0 with fresh k in CALC, else the following entry.
  always_comb begin
    ksel   = (state_q == CALC) ? k_calc : k_q;
    sel    = (state_q == CALC) ? '0 : ptr_q + LOG2_N'(1);
    u_sel  = buf_q[sel];
    mask   = ~({LW{1'b1}} << ksel);
    msb_d  = u_sel >> ksel;
    lsb_d  = (LW'(1) << ksel) | (LW'(u_sel) & mask);
    bits_d = BW'(msb_d) + BW'(ksel) + BW'(1);
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q   <= FILL;
      ptr_q     <= '0;
      sum_q     <= '0;
      k_q       <= '0;
      oValid    <= 1'b0;
      oMSB      <= '0;
      oLSB      <= '0;
      oBitsUsed <= '0;
      oFirst    <= 1'b0;
      oLast     <= 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (take) begin
            buf_q[ptr_q] <= u_in;
            sum_q        <= sum_q + SW'(u_in);
            ptr_q        <= ptr_q + LOG2_N'(1);
            if (ptr_q == LOG2_N'(N - 1)) state_q <= CALC;
          end
        end
        CALC: begin
          k_q       <= k_calc;
          sum_q     <= '0;
          state_q   <= EMIT;
          oValid    <= 1'b1;
          oMSB      <= msb_d;
          oLSB      <= lsb_d;
          oBitsUsed <= bits_d;
          oFirst    <= 1'b1;
          oLast     <= (N == 1);
        end
        EMIT: begin
          if (hs) begin
            if (oLast) begin
              state_q <= FILL;
              ptr_q   <= '0;
              oValid  <= 1'b0;
              oFirst  <= 1'b0;
              oLast   <= 1'b0;
            end else begin
              ptr_q     <= sel;
              oMSB      <= msb_d;
              oLSB      <= lsb_d;
              oBitsUsed <= bits_d;
              oFirst    <= 1'b0;
              oLast     <= (sel == LOG2_N'(N - 1));
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

`ifdef RICE_PART_BITS_EN
  logic [SW:0] part_q;
  assign oPartBits = part_q;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      part_q <= '0;
    end else if (state_q == CALC) begin
      part_q <= (SW + 1)'(bits_d);
    end else if (state_q == EMIT && hs && !oLast) begin
      part_q <= part_q + (SW + 1)'(bits_d);
    end
  end
`endif

endmodule

// File: tb/tb_adaptive_rice_encoder.sv
// Randomized self-checking bench for adaptive_rice_encoder (N=4 partitions).
module tb_adaptive_rice_encoder;

  localparam int W  = 16;
  localparam int L  = 2;
  localparam int N  = 4;
  localparam int KM = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          iv;
  logic          ir;
  logic [W-1:0]  smp;
  logic          o_ready;
  logic          o_valid;
  logic [W-1:0]  o_msb;
  logic [KM:0]   o_lsb;
  logic [W:0]    o_bits;
  logic [3:0]    o_param;
  logic          o_first;
  logic          o_last;
`ifdef RICE_PART_BITS_EN
  logic [W+L:0]  o_pb;
`endif

  adaptive_rice_encoder #(.WIDTH(W), .LOG2_N(L), .KMAX(KM)) dut (
    .iClock   (clk),
    .iReset   (rst),
    .iValid   (iv),
    .iSample  (smp),
    .oReady   (o_ready),
    .oValid   (o_valid),
    .iReady   (ir),
    .oMSB     (o_msb),
    .oLSB     (o_lsb),
    .oBitsUsed(o_bits),
    .oParam   (o_param),
    .oFirst   (o_first),
    .oLast    (o_last)
`ifdef RICE_PART_BITS_EN
    ,
    .oPartBits(o_pb)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] msb;
    logic [KM:0]  lsb;
    logic [W:0]   bits;
    logic [3:0]   k;
    logic         first;
    logic         last;
  } word_t;

  int    vectors = 0;
  int    errors  = 0;
  int    xs [N];
  word_t got [N];
  word_t exp_w [N];
  int    exp_pb;
  int    got_pb;
  int    cyc, stall_err, rdy_err;
  bit    tmo;

  function automatic int zz(input int x);
    return (x >= 0) ? 2 * x : -2 * x - 1;
  endfunction

  // k = floor(log2(S/N)) clamped to KM; code fields by plain arithmetic.
  function automatic void build_exp();
    int s, avg, k, u, q, r;
    s = 0;
    for (int i = 0; i < N; i++) s += zz(xs[i]);
    avg = s / N;
    k = 0;
    while (k < KM && (avg >> (k + 1)) != 0) k++;
    exp_pb = 0;
    for (int i = 0; i < N; i++) begin
      u = zz(xs[i]);
      q = u / (1 << k);
      r = u % (1 << k);
      exp_w[i].msb   = W'(q);
      exp_w[i].lsb   = (KM + 1)'((1 << k) + r);
      exp_w[i].bits  = (W + 1)'(q + k + 1);
      exp_w[i].k     = 4'(k);
      exp_w[i].first = (i == 0);
      exp_w[i].last  = (i == N - 1);
      exp_pb += q + k + 1;
    end
  endfunction

  task automatic send();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      iv  = 1'b1;
      smp = W'(xs[i]);
    end
    @(negedge clk);
    iv = 1'b0;
  endtask

  // mode 0: iReady high; 1: pattern 1,0,0,1; 2: random.
  task automatic collect(input int mode);
    int    n;
    bit    stalled;
    word_t w;
    logic [$bits(word_t):0] cur, prev;
    n = 0; stalled = 0; prev = '0;
    cyc = 0; stall_err = 0; rdy_err = 0; tmo = 0; got_pb = -1;
    while (n < N && !tmo) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       ir = 1'b1;
        1:       ir = (cyc % 4 == 1) || (cyc % 4 == 0);
        default: ir = 1'($urandom_range(0, 1));
      endcase
      w   = {o_msb, o_lsb, o_bits, o_param, o_first, o_last};
      cur = {o_valid, w};
      if (o_ready) rdy_err++;
      if (stalled && cur !== prev) stall_err++;
      stalled = o_valid && !ir;
      prev = cur;
      if (o_valid && ir) begin
        got[n] = w;
`ifdef RICE_PART_BITS_EN
        if (o_last) got_pb = int'(o_pb);
`endif
        n++;
      end
      if (cyc >= 200) tmo = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; iv = 1'b0; ir = 1'b0; smp = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({o_valid, o_msb, o_lsb, o_bits, o_param, o_first, o_last} !== '0
        || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b msb=%h lsb=%h bits=%h k=%h want ready=1 rest 0",
               o_ready, o_valid, o_msb, o_lsb, o_bits, o_param);
    end
`ifdef RICE_PART_BITS_EN
    vectors++;
    if (o_pb !== '0) begin
      errors++;
      $display("FAIL reset_partbits: got %0d want 0", o_pb);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int kk [4];
    int cases [4][N];
    kk    = '{3, 0, 14, 0};
    cases = '{'{5, 5, 5, 5}, '{0, -1, 1, -2},
              '{-32768, -32768, -32768, -32768}, '{0, 0, 0, 0}};
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) xs[i] = cases[t][i];
      build_exp();
      send();
      collect(0);
      vectors++;
      if (tmo || cyc != N) begin
        errors++;
        $display("FAIL directed%0d_latency: cycles %0d timeout %0d want %0d", t, cyc, tmo, N);
      end
      vectors++;
      if (got[0].k !== 4'(kk[t])) begin
        errors++;
        $display("FAIL directed%0d_k: got %0d want %0d", t, got[0].k, kk[t]);
      end
      for (int i = 0; i < N; i++) begin
        vectors++;
        if (got[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL directed%0d_code%0d: got %h want %h", t, i, got[i], exp_w[i]);
        end
      end
`ifdef RICE_PART_BITS_EN
      vectors++;
      if (got_pb !== exp_pb) begin
        errors++;
        $display("FAIL directed%0d_partbits: got %0d want %0d", t, got_pb, exp_pb);
      end
`endif
    end
  endtask

  task automatic test_stall();
    xs = '{5, -7, 300, -4000};
    build_exp();
    send();
    collect(1);
    vectors++;
    if (tmo || stall_err != 0 || rdy_err != 0) begin
      errors++;
      $display("FAIL stall: timeout %0d unstable %0d ready_high %0d want 0 0 0",
               tmo, stall_err, rdy_err);
    end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (got[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL stall_code%0d: got %h want %h", i, got[i], exp_w[i]);
      end
    end
    @(negedge clk);
    vectors++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_return: ready %b valid %b want 1 0", o_ready, o_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); iv = 1'b1; smp = W'(123);
    @(negedge clk); smp = W'(-77);
    @(negedge clk); iv = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    vectors++;
    if ({o_valid, o_msb, o_lsb, o_bits, o_param, o_first, o_last} !== '0
        || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_fill: ready %b valid %b msb %h want ready=1 rest 0",
               o_ready, o_valid, o_msb);
    end
    xs = '{900, 900, 900, 900};
    send();
    @(negedge clk); ir = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    vectors++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_param !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_emit: valid %b ready %b k %0d want 0 1 0",
               o_valid, o_ready, o_param);
    end
    xs = '{5, 5, 5, 5};
    build_exp();
    send();
    collect(0);
    vectors++;
    if (tmo || cyc != N) begin
      errors++;
      $display("FAIL reset_mid_count: cycles %0d timeout %0d want %0d", cyc, tmo, N);
    end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (got[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL reset_mid_code%0d: got %h want %h", i, got[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_random();
    logic signed [W-1:0] v;
    int sh;
    for (int p = 0; p < 40; p++) begin
      sh = $urandom_range(0, 15);
      for (int i = 0; i < N; i++) begin
        v = W'($urandom);
        xs[i] = int'(v >>> sh);
        if ($urandom_range(0, 15) == 0) xs[i] = -32768;
      end
      build_exp();
      send();
      collect(p % 2 == 0 ? 2 : 0);
      vectors++;
      if (tmo || stall_err != 0 || rdy_err != 0) begin
        errors++;
        $display("FAIL random%0d_flow: timeout %0d unstable %0d ready_high %0d want 0 0 0",
                 p, tmo, stall_err, rdy_err);
      end
      for (int i = 0; i < N; i++) begin
        vectors++;
        if (got[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL random%0d_code%0d: got %h want %h", p, i, got[i], exp_w[i]);
        end
      end
`ifdef RICE_PART_BITS_EN
      vectors++;
      if (got_pb !== exp_pb) begin
        errors++;
        $display("FAIL random%0d_partbits: got %0d want %0d", p, got_pb, exp_pb);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
